// File: rtl/morse_pkg.sv
// Shared definitions for the serial Morse digit transmitter.
// Holds the FSM state encoding, element constants and the digit-to-pattern encoder.
package morse_pkg;

    // Number of elements in every digit pattern.
    localparam int unsigned ELEMS = 5;

    // Element symbols inside a pattern.
    localparam logic MORSE_DOT  = 1'b0;
    localparam logic MORSE_DASH = 1'b1;

    // Pattern shown on codigo while in reset.
    localparam logic [ELEMS-1:0] CODIGO_RST = 5'b01010;

    // FSM state encoding; kept as plain constants so older tools can consume it.
    typedef logic [2:0] morse_state_t;
    localparam morse_state_t ST_IDLE     = 3'd0;
    localparam morse_state_t ST_MARK     = 3'd1;
    localparam morse_state_t ST_GAP_EL   = 3'd2;
    localparam morse_state_t ST_GAP_CHAR = 3'd3;
    localparam morse_state_t ST_GAP_WORD = 3'd4;

    // Digit to 5-element pattern, first element in the MSB; 1 = dash.
    // 1..5 start with d dots, 6..9 start with (d-5) dashes, 0 is all dashes.
    function automatic logic [ELEMS-1:0] digit_to_morse(input logic [3:0] digit);
        logic [ELEMS-1:0] code;
        int unsigned      n;
        code = '0;
        n    = 32'(digit);
        for (int unsigned i = 0; i < ELEMS; i++) begin
            if (n >= 1 && n <= 5) begin
                code = {code[ELEMS-2:0], (i < n) ? MORSE_DOT : MORSE_DASH};
            end else if (n >= 6 && n <= 9) begin
                code = {code[ELEMS-2:0], (i < n - 5) ? MORSE_DASH : MORSE_DOT};
            end else begin
                code = {code[ELEMS-2:0], MORSE_DASH};
            end
        end
        return code;
    endfunction

endpackage

// File: rtl/morse_fifo.sv
// Small synchronous FIFO buffering accepted digits ahead of the Morse keyer.
// DEPTH must be a power of two so the pointers wrap on their own.
module morse_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             wdata_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             rdata_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Qualify requests and compute next pointers and occupancy.
    always_comb begin
        do_pop   = pop_i && !empty_o;
        // A full FIFO still takes a push when the head leaves in the same cycle.
        do_push  = push_i && (!full_o || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
    end

    // Pointer and occupancy state; cleared asynchronously.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/morse_tx_serial.sv
// Serial Morse transmitter: buffers BCD digits and keys saida_luz with Morse timing.
// Optional build macro MORSE_WORD_GAP_EN extends the silence after the last queued
// character to a full 7-unit word gap.
module morse_tx_serial
    import morse_pkg::*;
#(
    parameter int unsigned UNIT_CYCLES = 4,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned DASH_UNITS  = 3
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [3:0] entrada,
    input  logic       valido,
    output logic       pronto,
    output logic       saida_luz,
    output logic [4:0] codigo,
    output logic       ocupado,
    output logic       erro
);

    localparam int unsigned DashCycles = DASH_UNITS * UNIT_CYCLES;
`ifdef MORSE_WORD_GAP_EN
    localparam int unsigned WordCycles = (7 - DASH_UNITS) * UNIT_CYCLES;
    localparam int unsigned TimerMax   = (WordCycles > DashCycles) ? WordCycles : DashCycles;
`else
    localparam int unsigned TimerMax   = DashCycles;
`endif
    localparam int unsigned TW = $clog2(TimerMax + 1);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    // FIFO interface
    logic          fifo_push;
    logic          fifo_pop;
    logic [3:0]    fifo_rdata;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] count_nxt;
    logic          accept;

    // Handshake state
    logic pronto_q, pronto_d;
    logic erro_q, erro_d;

    // Keyer state
    morse_state_t state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    elem_q, elem_d;
    logic [4:0]    codigo_q, codigo_d;
    logic          saida_q, saida_d;

    // Timer load value for a mark; the timer counts down to zero inclusive.
    function automatic logic [TW-1:0] mark_load(input logic elem);
        return (elem == MORSE_DASH) ? TW'(DashCycles - 1) : TW'(UNIT_CYCLES - 1);
    endfunction

    morse_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (4)
    ) u_fifo (
        .clk_i   (clock),
        .rst_ni  (reset_n),
        .push_i  (fifo_push),
        .wdata_i (entrada),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Accept digits, flag out-of-range values and predict next-cycle readiness.
    always_comb begin
        accept    = valido && pronto_q;
        fifo_push = accept && (entrada <= 4'd9) && (!fifo_full || fifo_pop);
        erro_d    = accept && (entrada > 4'd9);
        // pronto is registered, so it must reflect the occupancy after this edge.
        count_nxt = fifo_count + CW'(fifo_push) - CW'(fifo_pop);
        pronto_d  = (count_nxt != CW'(DEPTH));
    end

    // Handshake registers; pronto stays low throughout reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pronto_q <= 1'b0;
            erro_q   <= 1'b0;
        end else begin
            pronto_q <= pronto_d;
            erro_q   <= erro_d;
        end
    end

    // Keyer FSM next state: timer is reloaded on every state entry and expires at zero.
    always_comb begin
        state_d  = state_q;
        elem_d   = elem_q;
        codigo_d = codigo_q;
        fifo_pop = 1'b0;
        timer_d  = (timer_q != '0) ? timer_q - 1'b1 : timer_q;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    codigo_d = digit_to_morse(fifo_rdata);
                    elem_d   = '0;
                    state_d  = ST_MARK;
                    timer_d  = mark_load(codigo_d[ELEMS-1]);
                end
            end
            ST_MARK: begin
                if (timer_q == '0) begin
                    if (elem_q < 3'(ELEMS - 1)) begin
                        state_d = ST_GAP_EL;
                        timer_d = TW'(UNIT_CYCLES - 1);
                    end else begin
                        state_d = ST_GAP_CHAR;
                        timer_d = TW'(DashCycles - 1);
                    end
                end
            end
            ST_GAP_EL: begin
                if (timer_q == '0) begin
                    elem_d  = elem_q + 3'd1;
                    state_d = ST_MARK;
                    // Next element sits one bit below the current one.
                    timer_d = mark_load(codigo_q[3'd3 - elem_q]);
                end
            end
            ST_GAP_CHAR: begin
                if (timer_q == '0) begin
`ifdef MORSE_WORD_GAP_EN
                    // Nothing queued: stretch the silence to a word gap.
                    if (fifo_empty) begin
                        state_d = ST_GAP_WORD;
                        timer_d = TW'(WordCycles - 1);
                    end else begin
                        state_d = ST_IDLE;
                    end
`else
                    state_d = ST_IDLE;
`endif
                end
            end
`ifdef MORSE_WORD_GAP_EN
            ST_GAP_WORD: begin
                // Runs to completion even if a digit arrives meanwhile.
                if (timer_q == '0) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        saida_d = (state_d == ST_MARK);
    end

    // Keyer registers; reset drops the lamp immediately and restores the idle pattern.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            timer_q  <= '0;
            elem_q   <= '0;
            codigo_q <= CODIGO_RST;
            saida_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            elem_q   <= elem_d;
            codigo_q <= codigo_d;
            saida_q  <= saida_d;
        end
    end

    assign pronto    = pronto_q;
    assign erro      = erro_q;
    assign saida_luz = saida_q;
    assign codigo    = codigo_q;
    assign ocupado   = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_morse_tx_serial.sv
// Self-checking bench for morse_tx_serial with UNIT_CYCLES=2, DASH_UNITS=3, DEPTH=4.
// Expected waveforms come from a Morse table and timing arithmetic, not the RTL.
module tb_morse_tx_serial;

    localparam int UNIT   = 2;
    localparam int DASH   = 3;
    localparam int DEPTH  = 4;
    localparam int DOT_T  = UNIT;
    localparam int DASH_T = DASH * UNIT;
`ifdef MORSE_WORD_GAP_EN
    localparam int WORD_T = (7 - DASH) * UNIT;
`else
    localparam int WORD_T = 0;
`endif

    logic       clock   = 1'b0;
    logic       reset_n = 1'b0;
    logic       valido  = 1'b0;
    logic [3:0] entrada = 4'd0;
    logic       pronto;
    logic       saida_luz;
    logic [4:0] codigo;
    logic       ocupado;
    logic       erro;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    morse_tx_serial #(
        .UNIT_CYCLES (UNIT),
        .DEPTH       (DEPTH),
        .DASH_UNITS  (DASH)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .entrada   (entrada),
        .valido    (valido),
        .pronto    (pronto),
        .saida_luz (saida_luz),
        .codigo    (codigo),
        .ocupado   (ocupado),
        .erro      (erro)
    );

    // International Morse digits.
    function automatic string ref_str(input int d);
        case (d)
            0: return "-----";
            1: return ".----";
            2: return "..---";
            3: return "...--";
            4: return "....-";
            5: return ".....";
            6: return "-....";
            7: return "--...";
            8: return "---..";
            9: return "----.";
            default: return ".....";
        endcase
    endfunction

    function automatic logic [4:0] ref_code(input int d);
        string      s;
        logic [4:0] c;
        s = ref_str(d);
        c = '0;
        for (int i = 0; i < 5; i++) c = {c[3:0], (s[i] == "-")};
        return c;
    endfunction

    // Cycles from pop until the keyer is idle again.
    function automatic int char_len(input int d);
        string s;
        int    l;
        s = ref_str(d);
        l = 4 * UNIT + DASH_T;
        for (int i = 0; i < 5; i++) l += (s[i] == "-") ? DASH_T : DOT_T;
        return l;
    endfunction

    // Called at a negedge; offers one digit, waiting (bounded) for pronto.
    task automatic push_digit(input logic [3:0] d);
        int n = 0;
        while (pronto !== 1'b1 && n < 400) begin
            @(negedge clock);
            n++;
        end
        total++;
        if (pronto !== 1'b1) begin
            bad++;
            $display("FAIL push_wait: pronto=%b required 1", pronto);
        end
        entrada = d;
        valido  = 1'b1;
        @(negedge clock);
        valido  = 1'b0;
    endtask

    // Sends a message while watching every output cycle against the timing model.
    task automatic send_and_watch(input string name, input int digs[$]);
        bit         e_luz[$];
        bit         e_busy[$];
        logic [4:0] e_cod[$];
        logic [4:0] c;
        string      s;
        foreach (digs[j]) begin
            c = ref_code(digs[j]);
            s = ref_str(digs[j]);
            for (int i = 0; i < 5; i++) begin
                for (int t = 0; t < ((s[i] == "-") ? DASH_T : DOT_T); t++) begin
                    e_luz.push_back(1'b1); e_cod.push_back(c); e_busy.push_back(1'b1);
                end
                if (i < 4) begin
                    for (int t = 0; t < UNIT; t++) begin
                        e_luz.push_back(1'b0); e_cod.push_back(c); e_busy.push_back(1'b1);
                    end
                end
            end
            for (int t = 0; t < DASH_T; t++) begin
                e_luz.push_back(1'b0); e_cod.push_back(c); e_busy.push_back(1'b1);
            end
            if (j < digs.size() - 1) begin
                e_luz.push_back(1'b0); e_cod.push_back(c); e_busy.push_back(1'b1);
            end
        end
        for (int t = 0; t < WORD_T; t++) begin
            e_luz.push_back(1'b0); e_cod.push_back(c); e_busy.push_back(1'b1);
        end
        for (int t = 0; t < 4; t++) begin
            e_luz.push_back(1'b0); e_cod.push_back(c); e_busy.push_back(1'b0);
        end

        fork
            begin
                foreach (digs[j]) push_digit(4'(digs[j]));
            end
            begin
                @(negedge clock);
                total++;
                if (saida_luz !== 1'b0 || ocupado !== 1'b1) begin
                    bad++;
                    $display("FAIL %s accept: luz/busy=%b/%b required 0/1", name, saida_luz,
                             ocupado);
                end
                foreach (e_luz[k]) begin
                    @(negedge clock);
                    total++;
                    if (saida_luz !== e_luz[k] || codigo !== e_cod[k] ||
                        ocupado !== e_busy[k] || erro !== 1'b0) begin
                        bad++;
                        $display("FAIL %s cycle %0d: luz/cod/busy/erro=%b/%b/%b/%b required %b/%b/%b/0",
                                 name, k, saida_luz, codigo, ocupado, erro, e_luz[k], e_cod[k],
                                 e_busy[k]);
                    end
                end
            end
        join
    endtask

    task automatic test_reset();
        #12;
        total++;
        if (saida_luz !== 1'b0 || codigo !== 5'b01010 || ocupado !== 1'b0 || erro !== 1'b0 ||
            pronto !== 1'b0) begin
            bad++;
            $display("FAIL reset_vals: luz/cod/busy/erro/pronto=%b/%b/%b/%b/%b required 0/01010/0/0/0",
                     saida_luz, codigo, ocupado, erro, pronto);
        end
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        total++;
        if (pronto !== 1'b1 || ocupado !== 1'b0 || saida_luz !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: pronto/busy/luz=%b/%b/%b required 1/0/0", pronto,
                     ocupado, saida_luz);
        end
    endtask

    task automatic test_single();
        send_and_watch("single5", '{5});
        total++;
        if (codigo !== 5'b00000) begin
            bad++;
            $display("FAIL single5_codigo: codigo=%b required 00000", codigo);
        end
        send_and_watch("single9", '{9});
        total++;
        if (codigo !== 5'b11110) begin
            bad++;
            $display("FAIL single9_codigo: codigo=%b required 11110", codigo);
        end
    endtask

    task automatic test_back_to_back();
        send_and_watch("b2b_0_1", '{0, 1});
        total++;
        if (codigo !== 5'b01111) begin
            bad++;
            $display("FAIL b2b_codigo: codigo=%b required 01111", codigo);
        end
    endtask

    task automatic test_fill();
        int d[$];
        int base, sum_l, n, want;
        for (int i = 0; i < 6; i++) d.push_back(int'($urandom_range(0, 9)));
        sum_l = 0;
        foreach (d[i]) sum_l += char_len(d[i]);
        base = cyc;
        for (int i = 0; i < 5; i++) push_digit(4'(d[i]));
        total++;
        if (pronto !== 1'b0) begin
            bad++;
            $display("FAIL fill_full: pronto=%b required 0", pronto);
        end
        n = 0;
        while (pronto !== 1'b1 && n < 200) begin
            @(negedge clock);
            n++;
        end
        want = 3 + char_len(d[0]);
        total++;
        if (cyc - base !== want) begin
            bad++;
            $display("FAIL fill_reopen: pronto rose at %0d required %0d", cyc - base, want);
        end
        push_digit(4'(d[5]));
        n = 0;
        while (ocupado !== 1'b0 && n < 2000) begin
            @(negedge clock);
            n++;
        end
        want = sum_l + 7 + WORD_T;
        total++;
        if (cyc - base !== want) begin
            bad++;
            $display("FAIL fill_drain: idle at %0d required %0d", cyc - base, want);
        end
        total++;
        if (codigo !== ref_code(d[5]) || saida_luz !== 1'b0) begin
            bad++;
            $display("FAIL fill_last: codigo/luz=%b/%b required %b/0", codigo, saida_luz,
                     ref_code(d[5]));
        end
    endtask

    task automatic test_error();
        logic [3:0] v;
        for (int r = 0; r < 3; r++) begin
            v = (r == 0) ? 4'd12 : 4'($urandom_range(10, 15));
            entrada = v;
            valido  = 1'b1;
            @(negedge clock);
            valido  = 1'b0;
            total++;
            if (erro !== 1'b1 || ocupado !== 1'b0 || pronto !== 1'b1) begin
                bad++;
                $display("FAIL err_pulse(%0d): erro/busy/pronto=%b/%b/%b required 1/0/1", v, erro,
                         ocupado, pronto);
            end
            @(negedge clock);
            total++;
            if (erro !== 1'b0 || saida_luz !== 1'b0 || ocupado !== 1'b0) begin
                bad++;
                $display("FAIL err_after(%0d): erro/luz/busy=%b/%b/%b required 0/0/0", v, erro,
                         saida_luz, ocupado);
            end
        end
        repeat (4) @(negedge clock);
        total++;
        if (saida_luz !== 1'b0 || ocupado !== 1'b0) begin
            bad++;
            $display("FAIL err_quiet: luz/busy=%b/%b required 0/0", saida_luz, ocupado);
        end
    endtask

    task automatic test_random();
        int d[$];
        int n;
        for (int r = 0; r < 3; r++) begin
            d.delete();
            n = int'($urandom_range(1, 7));
            for (int i = 0; i < n; i++) d.push_back(int'($urandom_range(0, 9)));
            send_and_watch($sformatf("rand%0d", r), d);
        end
    endtask

    task automatic test_reset_mid();
        int marks;
        push_digit(4'd0);
        push_digit(4'd7);
        push_digit(4'd3);
        repeat (2) @(negedge clock);
        total++;
        if (saida_luz !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_in_dash: luz=%b required 1", saida_luz);
        end
        reset_n = 1'b0;
        #1;
        total++;
        if (saida_luz !== 1'b0 || codigo !== 5'b01010 || ocupado !== 1'b0 || pronto !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_async: luz/cod/busy/pronto=%b/%b/%b/%b required 0/01010/0/0",
                     saida_luz, codigo, ocupado, pronto);
        end
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        total++;
        if (pronto !== 1'b1 || ocupado !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_release: pronto/busy=%b/%b required 1/0", pronto, ocupado);
        end
        marks = 0;
        repeat (40) begin
            @(negedge clock);
            if (saida_luz !== 1'b0 || ocupado !== 1'b0) marks++;
        end
        total++;
        if (marks !== 0) begin
            bad++;
            $display("FAIL rstmid_residual: active cycles=%0d required 0", marks);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_fill();
        test_error();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
